// File: rtl/conv3_window_gen_if.sv
// Pixel-in / window-out bundle of the 3x3 sliding-window generator.
// The generator is the slave; the pixel source and window consumer form the master side.
interface conv3_window_gen_if #(
    parameter int CH = 16,
    parameter int DW = 8
);
    logic                in_valid;
    logic                in_sof;
    logic [CH*DW-1:0]    in_act;
    logic                out_valid;
    logic [CH*9*DW-1:0]  out_act;
    logic                out_last;

    modport master (
        output in_valid, in_sof, in_act,
        input  out_valid, out_act, out_last
    );

    modport slave (
        input  in_valid, in_sof, in_act,
        output out_valid, out_act, out_last
    );
endinterface

// File: rtl/conv3_window_gen.sv
// Raster-order pixel stream to 3x3xCH window generator (stride 1, no padding).
// Two line buffers plus a 3x3 register window; one registered window per valid position.
module conv3_window_gen #(
    parameter int CH    = 16,
    parameter int DW    = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic              clk,
    input  logic              rstn,
    conv3_window_gen_if.slave bus
);
    localparam int PW = CH * DW;
    localparam int OW = 9 * PW;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d, wr_col;
    logic [RW-1:0] row_q, row_d;
    logic          load, emit, last;

    logic [PW-1:0] lb0 [IMG_W];
    logic [PW-1:0] lb1 [IMG_W];
    logic [PW-1:0] win_q [3][3];
    logic [PW-1:0] win_d [3][3];
    logic [OW-1:0] packed_win;

    // An sof beat is always pixel (0,0), whatever the counters hold.
    assign wr_col = bus.in_sof ? '0 : col_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        load    = 1'b0;
        emit    = 1'b0;
        last    = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_sof) begin
                state_d = FILL;
                row_d   = '0;
                col_d   = CW'(1);
                load    = 1'b1;
            end else if (state_q != IDLE) begin
                load = 1'b1;
                if (col_q == COL_MAX) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
                if (state_q == FILL && row_q == RW'(1) && col_q == COL_MAX)
                    state_d = RUN;
                if (state_q == RUN) begin
                    emit = (col_q >= CW'(2));
                    if (row_q == ROW_MAX && col_q == COL_MAX) begin
                        state_d = IDLE;
                        row_d   = '0;
                        col_d   = '0;
                        last    = 1'b1;
                    end
                end
            end
        end
    end

    // Window after this beat: shift left, new right column read before the line-buffer write.
    always_comb begin
        for (int ky = 0; ky < 3; ky++) begin
            win_d[ky][0] = win_q[ky][1];
            win_d[ky][1] = win_q[ky][2];
        end
        win_d[0][2] = lb1[wr_col];
        win_d[1][2] = lb0[wr_col];
        win_d[2][2] = bus.in_act;
    end

    always_comb begin
        packed_win = '0;
        for (int k = 0; k < CH; k++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    packed_win[k*9*DW + (ky*3+kx)*DW +: DW] = win_d[ky][kx][k*DW +: DW];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // NOTE: line buffers and window carry no reset; outputs are gated until fully refilled.
    always_ff @(posedge clk) begin
        if (load) begin
            lb1[wr_col] <= lb0[wr_col];
            lb0[wr_col] <= bus.in_act;
            win_q       <= win_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_act   <= '0;
        end else begin
            bus.out_valid <= emit;
            bus.out_last  <= last;
            if (emit)
                bus.out_act <= packed_win;
        end
    end
endmodule

// File: tb/tb_conv3_window_gen.sv
// Self-checking bench for conv3_window_gen: table vectors, directed frame sequences
// and randomized traffic compared against a whole-image reference model.
module tb_conv3_window_gen;
    localparam int CH = 16;
    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = CH * DW;
    localparam int OW = 9 * PW;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    conv3_window_gen_if #(.CH(CH), .DW(DW)) bus ();

    conv3_window_gen #(.CH(CH), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n_win    = 0;
    int n_last   = 0;

    // Reference model: the current frame as an image, addressed by beat index.
    logic [PW-1:0] img [H][W];
    logic [OW-1:0] m_act = '0;
    bit            m_active = 1'b0;
    int            m_n = 0;

    typedef struct {
        bit sof;
        int r;
        int c;
        bit exp_valid;
        bit exp_last;
    } vec_t;
    vec_t tbl [W*H];

    int taps_exp [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_act(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            int idx = 0;
            n_err++;
            for (int i = OW/DW - 1; i >= 0; i--)
                if (got[i*DW +: DW] !== exp[i*DW +: DW]) idx = i;
            $display("FAIL %s: byte %0d got %0h expected %0h", name, idx,
                     got[idx*DW +: DW], exp[idx*DW +: DW]);
        end
    endtask

    function automatic logic [PW-1:0] pix(input int base, input int r, input int c);
        logic [PW-1:0] p;
        for (int k = 0; k < CH; k++) p[k*DW +: DW] = DW'(base + r*16 + c + k);
        return p;
    endfunction

    function automatic logic [PW-1:0] rpix();
        logic [PW-1:0] p;
        for (int i = 0; i < PW/32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    task automatic model_beat(input bit sof, input logic [PW-1:0] p, output bit ev, output bit el);
        int r, c;
        ev = 1'b0;
        el = 1'b0;
        if (sof) begin
            m_active = 1'b1;
            m_n      = 0;
        end
        if (!m_active) return;
        r = m_n / W;
        c = m_n % W;
        img[r][c] = p;
        if (r >= 2 && c >= 2) begin
            ev = 1'b1;
            el = (m_n == W*H - 1);
            for (int k = 0; k < CH; k++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        m_act[k*9*DW + (ky*3+kx)*DW +: DW] = img[r-2+ky][c-2+kx][k*DW +: DW];
        end
        m_n++;
        if (m_n == W*H) m_active = 1'b0;
    endtask

    // One clock: drive on the falling edge, check #1 after the rising edge.
    task automatic cycle(input bit v, input bit s, input logic [PW-1:0] p);
        bit ev = 1'b0, el = 1'b0;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_act   = p;
        @(posedge clk);
        if (v) model_beat(s, p, ev, el);
        #1;
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
        check("out_last", {31'd0, bus.out_last}, {31'd0, el});
        check_act("out_act", bus.out_act, m_act);
        if (bus.out_valid) n_win++;
        if (bus.out_last)  n_last++;
    endtask

    task automatic check_taps();
        for (int t = 0; t < 9; t++)
            check($sformatf("tap%0d", t), {24'd0, bus.out_act[t*DW +: DW]}, taps_exp[t]);
    endtask

    task automatic frame(input int base, input int gapmax, input int nbeats, input bit taps);
        for (int n = 0; n < nbeats; n++) begin
            cycle(1'b1, n == 0, pix(base, n / W, n % W));
            if (taps && n == 2*W + 2) check_taps();
            if (gapmax > 0)
                repeat ($urandom_range(1, gapmax)) cycle(1'b0, 1'($urandom_range(0, 1)), rpix());
        end
    endtask

    task automatic expect_counts(input string name, input int wins, input int lasts);
        check({name, "_windows"}, n_win, wins);
        check({name, "_lasts"}, n_last, lasts);
        n_win  = 0;
        n_last = 0;
    endtask

    initial begin
        for (int n = 0; n < W*H; n++) tbl[n] = '{n == 0, n / W, n % W, 1'b0, 1'b0};
        tbl[12].exp_valid = 1'b1;
        tbl[13].exp_valid = 1'b1;
        tbl[14].exp_valid = 1'b1;
        tbl[17].exp_valid = 1'b1;
        tbl[18].exp_valid = 1'b1;
        tbl[19].exp_valid = 1'b1;
        tbl[19].exp_last  = 1'b1;

        rstn         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_act   = '0;
        #3;
        check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_last", {31'd0, bus.out_last}, 32'd0);
        check_act("reset_act", bus.out_act, '0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // 1: continuous frame from the vector table
        for (int i = 0; i < W*H; i++) begin
            cycle(1'b1, tbl[i].sof, pix(0, tbl[i].r, tbl[i].c));
            check($sformatf("tbl_valid_%0d", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].exp_valid});
            check($sformatf("tbl_last_%0d", i), {31'd0, bus.out_last}, {31'd0, tbl[i].exp_last});
            if (i == 12) check_taps();
        end
        cycle(1'b0, 1'b0, '0);
        expect_counts("s1", 6, 1);

        // 2: same frame with 1-3 idle cycles after every beat
        frame(0, 3, W*H, 1'b1);
        expect_counts("s2", 6, 1);

        // 3: non-sof beats while idle are dropped
        repeat (4) cycle(1'b1, 1'b0, rpix());
        frame(0, 0, W*H, 1'b1);
        expect_counts("s3", 6, 1);

        // 4: sof at pixel (3,1) aborts, then a complete new frame
        frame(0, 0, 3*W + 1, 1'b0);
        frame(30, 0, W*H, 1'b0);
        expect_counts("s4", 9, 1);

        // 5: back-to-back frames with distinct data
        frame(10, 0, W*H, 1'b0);
        frame(120, 0, W*H, 1'b0);
        cycle(1'b0, 1'b0, '0);
        expect_counts("s5", 12, 2);

        // 6: asynchronous reset mid-RUN, right after an emitted window
        frame(50, 0, 2*W + 3, 1'b0);
        #2;
        rstn         = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("async_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async_last", {31'd0, bus.out_last}, 32'd0);
        check_act("async_act", bus.out_act, '0);
        m_active = 1'b0;
        m_act    = '0;
        n_win    = 0;
        n_last   = 0;
        @(negedge clk);
        rstn = 1'b1;
        frame(0, 0, W*H, 1'b1);
        expect_counts("s6", 6, 1);

        // 7: random beats, data and occasional sof
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, rpix());

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/conv3_window_gen.md
Name: conv3_window_gen

Overview:
Sliding-window generator that sits directly upstream of the 3x3 depthwise conv stage. It accepts a raster-order pixel stream of CH channels × DW bits. It buffers two image rows plus a 3x3 register window. For every valid ("no padding", stride 1) window position it emits the full 3x3×CH activation vector in the packing the depthwise stage consumes.

Parameters:
- CH, 16, channels per pixel
- DW, 8, bits per activation
- IMG_W, 16, image width in pixels (≥3)
- IMG_H, 16, image height in rows (≥3)

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- in_valid  in  1  pixel beat qualifier
- in_sof  in  1  first pixel of frame; sampled only when in_valid=1
- in_act  in  CH*DW  pixel; channel c at [c*DW +: DW]
- out_valid  out  1  window valid, one-cycle pulse per window; drives the conv stage's valid
- out_act  out  CH*9*DW  window
- out_last  out  1  high with out_valid on the final window of a frame

Behaviour:
- Reset: rstn asynchronous, active-low; clock clk. While in reset: out_valid=0, out_last=0, out_act=0, row/col counters=0, FSM=IDLE. Line-buffer and window storage are not reset; their contents are don't-care because outputs are gated.
- Only beats (in_valid=1) advance state. Idle cycles, including arbitrary gaps, hold all state. out_valid=0 on those cycles.
- FSM:
  - IDLE: beats with in_sof=0 are dropped. A beat with in_sof=1 is pixel (0,0): goto FILL, col=1.
  - FILL: rows 0–1 are loading; no output. Goto RUN on the beat at (row=1, col=IMG_W-1).
  - RUN: rows 2..IMG_H-1. The beat at (row=IMG_H-1, col=IMG_W-1) emits the last window, then goto IDLE.
  - in_sof=1 on a beat in FILL or RUN aborts the current frame. That beat becomes pixel (0,0) of a new frame: FSM=FILL, col=1, row=0. No out_last is issued for the aborted frame.
- Counters: col wraps IMG_W-1→0 with row+1. Widths are $clog2 of IMG_W and IMG_H, minimum 1.
- Storage:
  - Two line buffers, each IMG_W×CH*DW: lb1 = row r-2, lb0 = row r-1.
  - On a beat at column c: lb1[c]←lb0[c], lb0[c]←in_act.
  - 3x3 window register per channel. On each beat the window shifts left and loads the new right column {lb1[c], lb0[c], in_act}, read before the write.
  - The window is not cleared at row start. Stale columns are never emitted because of the col≥2 rule below.
- Emit rule: a beat at (row r≥2, col c≥2) produces a window covering rows r-2..r and cols c-2..c.
  - out_valid=1 exactly one cycle after that beat (latency 1, registered outputs).
  - out_act holds its value until the next emit.
- Packing:
  - Channel k occupies out_act[k*9*DW +: 9*DW].
  - Tap t=ky*3+kx sits at [t*DW +: DW] within the channel field. ky=0 is the top (oldest) row, kx=0 is the left (oldest) column.
  - Each channel takes the DW bits at [k*DW +: DW] of the stored pixel.
- Windows per frame: (IMG_H-2)*(IMG_W-2). out_last=1 only on the window from the beat at (IMG_H-1, IMG_W-1).
- Back-to-back frames: an in_sof beat may immediately follow the last pixel. The IDLE→FILL transition consumes it with no bubble.
- No backpressure: the consumer must accept one window per cycle.

Test Plan:
- Bench setup: IMG_W=5, IMG_H=4, CH=16; pixel (r,c) channel k = r*16+c+k.
1. Reset, then one continuous frame of 20 beats -> exactly 6 out_valid pulses, one cycle after beats (2,2),(2,3),(2,4),(3,2),(3,3),(3,4). First window, channel 0, taps 0..8 = 0,1,2,16,17,18,32,33,34. out_last only on the 6th pulse.
2. Same frame with a 1–3 cycle random gap after every beat -> identical 6 windows in order, each one cycle after its triggering beat. out_valid=0 during gaps.
3. Beats with in_sof=0 before the first in_sof -> dropped. The window contents match scenario 1.
4. in_sof re-asserted at pixel (3,1) of a frame, then a full new frame -> the 3 windows from row 2 are emitted, no out_last for the aborted frame; the new frame then yields 6 correct windows with out_last.
5. Two frames back-to-back, sof immediately after the last pixel -> 12 windows, out_last on the 6th and 12th. Windows of frame 2 contain no frame-1 data.
6. rstn asserted mid-RUN, asynchronously -> out_valid and out_last drop immediately and out_act=0. The next sof frame produces 6 correct windows.
